// File: rtl/fast_pwm_pkg.sv
// Shared defaults for the single-slope fast PWM block.
package fast_pwm_pkg;
  localparam int unsigned PWM_WIDTH = 32;
endpackage

// File: rtl/pwm_compare_channel.sv
// One PWM channel: shadowed compare value plus a registered comparator.
// The output reflects the counter value of the previous cycle.
module pwm_compare_channel
  import fast_pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] cmp_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             pwm_o
);

  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             pwm_q, pwm_d;

  // Reset also loads the shadow so the first period after release uses the live input.
  always_comb begin
    cmp_d = cmp_q;
    if (!rst_n_i || load_i) begin
      cmp_d = cmp_i;
    end
    pwm_d = rst_n_i && (cnt_i < cmp_q);
  end

  always_ff @(posedge clk_i) begin
    cmp_q <= cmp_d;
    pwm_q <= pwm_d;
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/fast_pwm.sv
// Single-slope fast PWM: counter 0..top_s, two compare channels, shadows reloaded at wrap.
// Outputs are registered and lag the counter by one cycle.
module fast_pwm
  import fast_pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] timer_top,
  input  logic [WIDTH-1:0] pwm_cnta,
  input  logic [WIDTH-1:0] pwm_cntb,
  output logic             pwm_outa,
  output logic             pwm_outb
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic             wrap;

  // Wrapping on equality with top_q keeps cnt_q + 1 within range, so no 2^WIDTH rollover.
  assign wrap = (cnt_q == top_q);

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    top_d = top_q;
    if (!reset) begin
      cnt_d = '0;
      top_d = timer_top;
    end else if (wrap) begin
      top_d = timer_top;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    top_q <= top_d;
  end

  pwm_compare_channel #(.WIDTH(WIDTH)) u_chan_a (
    .clk_i   (clk),
    .rst_n_i (reset),
    .load_i  (wrap),
    .cmp_i   (pwm_cnta),
    .cnt_i   (cnt_q),
    .pwm_o   (pwm_outa)
  );

  pwm_compare_channel #(.WIDTH(WIDTH)) u_chan_b (
    .clk_i   (clk),
    .rst_n_i (reset),
    .load_i  (wrap),
    .cmp_i   (pwm_cntb),
    .cnt_i   (cnt_q),
    .pwm_o   (pwm_outb)
  );

endmodule

// File: tb/tb_fast_pwm.sv
// Directed bench for fast_pwm: vector table of per-period duty plus multi-cycle corner sequences.
module tb_fast_pwm;

  logic        clk;
  logic        reset;
  logic [31:0] timer_top;
  logic [31:0] pwm_cnta;
  logic [31:0] pwm_cntb;
  logic        pwm_outa;
  logic        pwm_outb;

  int tests_run;
  int tests_failed;

  fast_pwm #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .timer_top (timer_top),
    .pwm_cnta  (pwm_cnta),
    .pwm_cntb  (pwm_cntb),
    .pwm_outa  (pwm_outa),
    .pwm_outb  (pwm_outb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] top;
    logic [31:0] cnta;
    logic [31:0] cntb;
    int          per;
    int          ha;
    int          hb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: one posedge with reset low, then release.
  task automatic apply_reset(input logic [31:0] top, input logic [31:0] ca, input logic [31:0] cb);
    timer_top = top;
    pwm_cnta  = ca;
    pwm_cntb  = cb;
    reset     = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
  endtask

  // Samples one period starting at a counter phase of 0; optionally changes inputs after sample chg_at.
  task automatic check_period(input int per, input int ha, input int hb, input string tag,
                              input int chg_at, input logic [31:0] chg_a, input logic [31:0] chg_top);
    int high_a, high_b, bad_a, bad_b;
    high_a = 0; high_b = 0; bad_a = 0; bad_b = 0;
    for (int j = 0; j < per; j++) begin
      @(negedge clk);
      if (pwm_outa) high_a++;
      if (pwm_outb) high_b++;
      if (pwm_outa !== (j < ha)) bad_a++;
      if (pwm_outb !== (j < hb)) bad_b++;
      if (j == chg_at) begin
        pwm_cnta  = chg_a;
        timer_top = chg_top;
      end
    end
    chk({tag, "_high_a"}, high_a, ha);
    chk({tag, "_high_b"}, high_b, hb);
    chk({tag, "_shape_a_errs"}, bad_a, 0);
    chk({tag, "_shape_b_errs"}, bad_b, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_cnt, bad_a, bad_b, waited;
    tests_run = 0;
    tests_failed = 0;

    vecs[0] = '{top: 100, cnta: 50,  cntb: 30,  per: 101, ha: 50,  hb: 30};
    vecs[1] = '{top: 100, cnta: 0,   cntb: 101, per: 101, ha: 0,   hb: 101};
    vecs[2] = '{top: 100, cnta: 100, cntb: 0,   per: 101, ha: 100, hb: 0};
    vecs[3] = '{top: 3,   cnta: 2,   cntb: 4,   per: 4,   ha: 2,   hb: 4};
    vecs[4] = '{top: 7,   cnta: 5,   cntb: 1,   per: 8,   ha: 5,   hb: 1};
    vecs[5] = '{top: 1,   cnta: 1,   cntb: 32'hFFFF_FFFF, per: 2, ha: 1, hb: 2};

    reset     = 1'b0;
    timer_top = 32'd100;
    pwm_cnta  = 32'd50;
    pwm_cntb  = 32'd30;
    repeat (3) @(negedge clk);
    chk("reset_outa", pwm_outa, 0);
    chk("reset_outb", pwm_outb, 0);
    chk("reset_cnt", dut.cnt_q, 0);

    foreach (vecs[i]) begin
      apply_reset(vecs[i].top, vecs[i].cnta, vecs[i].cntb);
      check_period(vecs[i].per, vecs[i].ha, vecs[i].hb, $sformatf("vec%0d_p0", i), -1, 0, 0);
      check_period(vecs[i].per, vecs[i].ha, vecs[i].hb, $sformatf("vec%0d_p1", i), -1, 0, 0);
    end

    // Compare change mid-period applies only from the next period.
    apply_reset(100, 50, 30);
    check_period(101, 50, 30, "cmpchg_cur", 9, 20, 100);
    check_period(101, 20, 30, "cmpchg_next", -1, 0, 0);

    // TOP and compare change mid-period together.
    apply_reset(100, 50, 30);
    check_period(101, 50, 30, "topchg_cur", 20, 4, 9);
    check_period(10, 4, 10, "topchg_next", -1, 0, 0);

    // top == 0: counter pinned at 0, outputs static.
    apply_reset(0, 1, 0);
    bad_cnt = 0; bad_a = 0; bad_b = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (dut.cnt_q !== 32'd0) bad_cnt++;
      if (pwm_outa !== 1'b1) bad_a++;
      if (pwm_outb !== 1'b0) bad_b++;
    end
    chk("top0_cnt_errs", bad_cnt, 0);
    chk("top0_outa_errs", bad_a, 0);
    chk("top0_outb_errs", bad_b, 0);

    // Reset mid-period, with new inputs captured during reset.
    apply_reset(100, 50, 30);
    waited = 0;
    while (dut.cnt_q !== 32'd60 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("midreset_reach_cnt60", (waited < 200), 1);
    reset     = 1'b0;
    timer_top = 32'd9;
    pwm_cnta  = 32'd3;
    pwm_cntb  = 32'd12;
    @(negedge clk);
    chk("midreset_outa", pwm_outa, 0);
    chk("midreset_outb", pwm_outb, 0);
    chk("midreset_cnt", dut.cnt_q, 0);
    reset = 1'b1;
    check_period(10, 3, 10, "midreset_p0", -1, 0, 0);
    check_period(10, 3, 10, "midreset_p1", -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fast_pwm.md
FAST_PWM -- requirements
Module: fast_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the bit width of the counter, TOP and compare values.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port timer_top, input, WIDTH bits: counter TOP value; period is timer_top+1 cycles.
REQ-005 SHALL have port pwm_cnta, input, WIDTH bits: compare value for channel A (high-cycle count).
REQ-006 SHALL have port pwm_cntb, input, WIDTH bits: compare value for channel B (high-cycle count).
REQ-007 SHALL have port pwm_outa, output, 1 bit: PWM output of channel A, registered.
REQ-008 SHALL have port pwm_outb, output, 1 bit: PWM output of channel B, registered.

Function
REQ-009 SHALL keep an internal unsigned WIDTH-bit up-counter cnt that counts 0, 1, ..., top_s, then wraps to 0 on the next edge (single-slope fast PWM).
REQ-010 SHALL hold shadow registers top_s, cmpa_s and cmpb_s; all counter and compare logic uses only the shadows.
REQ-011 SHALL load all three shadows from timer_top, pwm_cnta and pwm_cntb on the edge where cnt wraps (cnt == top_s); input changes mid-period take effect at the next period start.
REQ-012 SHALL register pwm_outa <= (cnt < cmpa_s) and pwm_outb <= (cnt < cmpb_s) on every non-reset edge, using cnt's pre-edge value; each output therefore lags its counter value by exactly 1 cycle.
REQ-013 SHALL use unsigned compare with no arithmetic overflow: the cnt+1 increment never exceeds top_s, so no wrap at 2^WIDTH occurs.
REQ-014 SHALL hold an output constantly low when its compare value is 0.
REQ-015 SHALL hold an output constantly high when its compare value is greater than top_s.
REQ-016 SHALL, when compare == top_s, drive the output high for top_s cycles and low for 1 cycle per period.
REQ-017 SHALL, when top_s == 0, keep cnt at 0 with a shadow reload every cycle; outputs are then high iff the compare value is greater than 0.
REQ-018 SHALL treat both channels independently with an identical period; simultaneous shadow updates are atomic.

Reset
REQ-019 SHALL, while reset is low at a rising clk edge, force cnt=0, pwm_outa=0 and pwm_outb=0.
REQ-020 SHALL, while reset is low, load top_s, cmpa_s and cmpb_s from the current inputs so the first period after release uses them.
REQ-021 SHALL restart from cnt=0 with a fresh period when reset is asserted mid-period; no partial state is retained.

Structure
REQ-022 SHALL take the WIDTH default from shared package fast_pwm_pkg; no other shared types are required.
REQ-023 SHALL implement each channel as sub-module pwm_compare_channel (shadow compare register + registered comparator), instantiated twice.
REQ-024 SHALL implement the counter and top_s shadow in fast_pwm itself.

Verification
REQ-025 SHALL verify: top=100, cnta=50, cntb=30, 10 ns clock, reset low 1 cycle -> outa high 50 / low 51 cycles, outb high 30 / low 71 cycles, period 101 cycles (1010 ns).
REQ-026 SHALL verify: cnta=0, cntb=101 with top=100 -> outa always 0, outb always 1 after the first post-reset edge.
REQ-027 SHALL verify: cnta changed 50->20 at cnt=10 -> current period keeps 50 high cycles; next period has 20 high cycles.
REQ-028 SHALL verify: top=0, cnta=1, cntb=0 -> cnt stays 0, outa constantly 1, outb constantly 0.
REQ-029 SHALL verify: reset asserted at cnt=60 -> next edge gives outputs 0 and cnt 0; after release, a full first period with correct duty.
REQ-030 SHALL verify: cnta=top=100 -> outa high 100 cycles and low 1 cycle per 101-cycle period.
